// File: rtl/clk_rst_mon_pkg.sv
// Shared types and defaults for the clock/reset monitor.
package clk_rst_mon_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int LOCK_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_EDGE,
        ST_MEASURE,
        ST_LOCKED
    } state_e;

endpackage

// File: rtl/clk_rst_mon_sync.sv
// N-flop single-bit synchronizer for signals asynchronous to clk.
module clk_rst_mon_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    always_comb sync_d = {sync_q[N-2:0], d_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/clk_rst_mon.sv
// Passive monitor: measures the period of an asynchronous clock in local cycles,
// tracks lock against [cfg_min_i, cfg_max_i] and flags short/long/stopped periods.
//   state        | meaning
//   ST_IDLE      | monitor disabled, counters and lock cleared
//   ST_WAIT_EDGE | waiting for first rising edge, no errors raised
//   ST_MEASURE   | measuring periods, not yet locked
//   ST_LOCKED    | required run of in-range periods seen
module clk_rst_mon
    import clk_rst_mon_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter bit RST_ACT_HIGH = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mon_clk_i,
    input  logic              mon_rst_i,
    input  logic              cfg_en_i,
    input  logic [CNT_W-1:0]  cfg_min_i,
    input  logic [CNT_W-1:0]  cfg_max_i,
    input  logic [LOCK_W-1:0] cfg_lock_n_i,
    input  logic              err_clr_i,
    output logic [CNT_W-1:0]  period_o,
    output logic              period_vld_o,
    output logic              locked_o,
    output logic              mon_rst_o,
    output logic              err_short_o,
    output logic              err_long_o
);

    logic mclk_s, mrst_s, mrst_act;

    // Normalise reset polarity before synchronizing so mrst_s is always active-high.
    assign mrst_act = RST_ACT_HIGH ? mon_rst_i : ~mon_rst_i;

    clk_rst_mon_sync #(.N(SYNC_STAGES)) u_sync_clk (
        .clk(clk), .rst_n(rst_n), .d_i(mon_clk_i), .q_o(mclk_s)
    );
    clk_rst_mon_sync #(.N(SYNC_STAGES)) u_sync_rst (
        .clk(clk), .rst_n(rst_n), .d_i(mrst_act), .q_o(mrst_s)
    );

    state_e            state_q, state_d;
    logic              mclk_prev_q, mclk_prev_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, period_q, period_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d, lock_n_eff, lock_inc;
    logic              period_vld_q, period_vld_d, locked_q, locked_d;
    logic              err_short_q, err_short_d, err_long_q, err_long_d;
    logic              edge_det, cnt_sat, too_short, too_long, stall;

    assign edge_det   = mclk_s & ~mclk_prev_q;
    assign cnt_sat    = &cnt_q;
    assign too_short  = cnt_q < cfg_min_i;
    assign too_long   = cnt_q > cfg_max_i;
    // Equality fires once per stall: the counter moves past cfg_max_i right after.
    assign stall      = !edge_det && !cnt_sat && (cnt_q == cfg_max_i);
    assign lock_n_eff = (cfg_lock_n_i == '0) ? LOCK_W'(1) : cfg_lock_n_i;
    assign lock_inc   = (&lock_cnt_q) ? lock_cnt_q : lock_cnt_q + LOCK_W'(1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lock_cnt_d   = lock_cnt_q;
        period_d     = period_q;
        period_vld_d = 1'b0;
        locked_d     = locked_q;
        err_short_d  = err_short_q & ~err_clr_i;
        err_long_d   = err_long_q & ~err_clr_i;
        mclk_prev_d  = mclk_s;

        if (!cfg_en_i) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end else if (mrst_s) begin
            state_d    = ST_WAIT_EDGE;
            cnt_d      = '0;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_WAIT_EDGE;
                ST_WAIT_EDGE: begin
                    if (edge_det) begin
                        cnt_d   = CNT_W'(1);
                        state_d = ST_MEASURE;
                    end
                end
                ST_MEASURE, ST_LOCKED: begin
                    if (edge_det) begin
                        period_d     = cnt_q;
                        period_vld_d = 1'b1;
                        cnt_d        = CNT_W'(1);
                        if (too_short || too_long) begin
                            if (too_short) err_short_d = 1'b1;
                            if (too_long)  err_long_d  = 1'b1;
                            lock_cnt_d = '0;
                            locked_d   = 1'b0;
                            state_d    = ST_MEASURE;
                        end else begin
                            lock_cnt_d = lock_inc;
                            if (lock_inc >= lock_n_eff) begin
                                locked_d = 1'b1;
                                state_d  = ST_LOCKED;
                            end
                        end
                    end else begin
                        cnt_d = cnt_sat ? cnt_q : cnt_q + CNT_W'(1);
                        if (stall) begin
                            err_long_d = 1'b1;
                            lock_cnt_d = '0;
                            locked_d   = 1'b0;
                            state_d    = ST_MEASURE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mclk_prev_q  <= 1'b0;
            cnt_q        <= '0;
            lock_cnt_q   <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            locked_q     <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mclk_prev_q  <= mclk_prev_d;
            cnt_q        <= cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
            locked_q     <= locked_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
        end
    end

    assign period_o     = period_q;
    assign period_vld_o = period_vld_q;
    assign locked_o     = locked_q;
    assign mon_rst_o    = mrst_s;
    assign err_short_o  = err_short_q;
    assign err_long_o   = err_long_q;

endmodule
